// File: rtl/alu_arbiter.sv
// Two-port arbiter that shares one combinational ALU and returns each result
// through a one-entry, owner-tagged output register with valid/ready handshakes.

`timescale 1ns/1ps

`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif
`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_SLL  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_SLT  4'd8
`define ALU_SLTU 4'd9
`endif

module alu (
    input  logic [`ALU_OP_WIDTH-1:0]     op_i,
    input  logic [`RISCV_WORD_WIDTH-1:0] a_i,
    input  logic [`RISCV_WORD_WIDTH-1:0] b_i,
    output logic [`RISCV_WORD_WIDTH-1:0] result_o
);
    localparam int XLEN = `RISCV_WORD_WIDTH;
    localparam int SHW  = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    logic           lt_signed;
    logic           lt_unsigned;

    assign shamt       = b_i[SHW-1:0];
    assign lt_signed   = $signed(a_i) < $signed(b_i);
    assign lt_unsigned = a_i < b_i;

    always_comb begin
        // NOTE: default assignment first, so every path drives result_o and no latch is inferred.
        result_o = '0;
        case (op_i)
            `ALU_ADD:  result_o = a_i + b_i;
            `ALU_SUB:  result_o = a_i - b_i;
            `ALU_AND:  result_o = a_i & b_i;
            `ALU_OR:   result_o = a_i | b_i;
            `ALU_XOR:  result_o = a_i ^ b_i;
            `ALU_SLL:  result_o = a_i << shamt;
            `ALU_SRL:  result_o = a_i >> shamt;
            `ALU_SRA:  result_o = $signed(a_i) >>> shamt;
            `ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_signed};
            `ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_unsigned};
            default:   result_o = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int RR_ENABLE = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,

    input  logic                         req0_valid_i,
    output logic                         req0_ready_o,
    input  logic [`ALU_OP_WIDTH-1:0]     req0_op_i,
    input  logic [`RISCV_WORD_WIDTH-1:0] req0_a_i,
    input  logic [`RISCV_WORD_WIDTH-1:0] req0_b_i,

    input  logic                         req1_valid_i,
    output logic                         req1_ready_o,
    input  logic [`ALU_OP_WIDTH-1:0]     req1_op_i,
    input  logic [`RISCV_WORD_WIDTH-1:0] req1_a_i,
    input  logic [`RISCV_WORD_WIDTH-1:0] req1_b_i,

    output logic                         rsp0_valid_o,
    input  logic                         rsp0_ready_i,
    output logic [`RISCV_WORD_WIDTH-1:0] rsp0_result_o,

    output logic                         rsp1_valid_o,
    input  logic                         rsp1_ready_i,
    output logic [`RISCV_WORD_WIDTH-1:0] rsp1_result_o,

    output logic                         busy_o,
    output logic [CNT_WIDTH-1:0]         grant_cnt0_o,
    output logic [CNT_WIDTH-1:0]         grant_cnt1_o
);
    localparam int XLEN = `RISCV_WORD_WIDTH;
    localparam int OPW  = `ALU_OP_WIDTH;

    logic                 out_valid_q, out_valid_d;
    logic                 out_owner_q, out_owner_d;
    logic [XLEN-1:0]      out_result_q, out_result_d;
    logic                 prio_q, prio_d;
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

    logic            rsp_fire;
    logic            can_accept;
    logic            grant;
    logic            accept;
    logic [OPW-1:0]  alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;

    // The register frees up in the same cycle its owner drains it.
    assign rsp_fire   = out_valid_q && (out_owner_q ? rsp1_ready_i : rsp0_ready_i);
    assign can_accept = !out_valid_q || rsp_fire;

    always_comb begin
        grant = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant = (RR_ENABLE != 0) ? prio_q : 1'b0;
        end else if (req1_valid_i) begin
            grant = 1'b1;
        end
    end

    assign accept       = can_accept && (req0_valid_i || req1_valid_i) && rst_ni;
    assign req0_ready_o = accept && !grant;
    assign req1_ready_o = accept && grant;

    // Port 0 drives the ALU whenever port 1 is not actually granted.
    always_comb begin
        alu_op = req0_op_i;
        alu_a  = req0_a_i;
        alu_b  = req0_b_i;
        if (accept && grant) begin
            alu_op = req1_op_i;
            alu_a  = req1_a_i;
            alu_b  = req1_b_i;
        end
    end

    alu u_alu (
        .op_i     (alu_op),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .result_o (alu_result)
    );

    always_comb begin
        out_valid_d  = out_valid_q;
        out_owner_d  = out_owner_q;
        out_result_d = out_result_q;
        prio_d       = prio_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_owner_d  = grant;
            out_result_d = alu_result;
            if (RR_ENABLE != 0) begin
                prio_d = ~grant;
            end
            if (!grant && cnt0_q != '1) begin
                cnt0_d = cnt0_q + CNT_WIDTH'(1);
            end
            if (grant && cnt1_q != '1) begin
                cnt1_d = cnt1_q + CNT_WIDTH'(1);
            end
        end else if (rsp_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: the result data register is reset too, so both result outputs read zero during reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_owner_q  <= 1'b0;
            out_result_q <= '0;
            prio_q       <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            out_valid_q  <= out_valid_d;
            out_owner_q  <= out_owner_d;
            out_result_q <= out_result_d;
            prio_q       <= prio_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign rsp0_valid_o  = out_valid_q && !out_owner_q;
    assign rsp1_valid_o  = out_valid_q && out_owner_q;
    assign rsp0_result_o = out_result_q;
    assign rsp1_result_o = out_result_q;
    assign busy_o        = out_valid_q;
    assign grant_cnt0_o  = cnt0_q;
    assign grant_cnt1_o  = cnt1_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin instance and a fixed-priority instance
// with narrow counters share one stimulus and are compared to a cycle model.

`timescale 1ns/1ps

module tb_alu_arbiter;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_BAD  = 4'd15;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid [2];
    logic [3:0]  req_op    [2];
    logic [31:0] req_a     [2];
    logic [31:0] req_b     [2];
    logic        rsp_ready [2];

    // Outputs indexed [instance][port]; instance 0 is round-robin, 1 is fixed priority.
    logic        o_req_ready  [2][2];
    logic        o_rsp_valid  [2][2];
    logic [31:0] o_rsp_result [2][2];
    logic        o_busy       [2];
    logic [31:0] o_cnt        [2][2];
    logic [15:0] rr_cnt0, rr_cnt1;
    logic [2:0]  fx_cnt0, fx_cnt1;

    assign o_cnt[0][0] = {16'd0, rr_cnt0};
    assign o_cnt[0][1] = {16'd0, rr_cnt1};
    assign o_cnt[1][0] = {29'd0, fx_cnt0};
    assign o_cnt[1][1] = {29'd0, fx_cnt1};

    always #5 clk_i = ~clk_i;

    alu_arbiter #(.RR_ENABLE(1), .CNT_WIDTH(16)) u_rr (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req0_valid_i(req_valid[0]), .req0_ready_o(o_req_ready[0][0]),
        .req0_op_i(req_op[0]), .req0_a_i(req_a[0]), .req0_b_i(req_b[0]),
        .req1_valid_i(req_valid[1]), .req1_ready_o(o_req_ready[0][1]),
        .req1_op_i(req_op[1]), .req1_a_i(req_a[1]), .req1_b_i(req_b[1]),
        .rsp0_valid_o(o_rsp_valid[0][0]), .rsp0_ready_i(rsp_ready[0]),
        .rsp0_result_o(o_rsp_result[0][0]),
        .rsp1_valid_o(o_rsp_valid[0][1]), .rsp1_ready_i(rsp_ready[1]),
        .rsp1_result_o(o_rsp_result[0][1]),
        .busy_o(o_busy[0]), .grant_cnt0_o(rr_cnt0), .grant_cnt1_o(rr_cnt1)
    );

    alu_arbiter #(.RR_ENABLE(0), .CNT_WIDTH(3)) u_fx (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req0_valid_i(req_valid[0]), .req0_ready_o(o_req_ready[1][0]),
        .req0_op_i(req_op[0]), .req0_a_i(req_a[0]), .req0_b_i(req_b[0]),
        .req1_valid_i(req_valid[1]), .req1_ready_o(o_req_ready[1][1]),
        .req1_op_i(req_op[1]), .req1_a_i(req_a[1]), .req1_b_i(req_b[1]),
        .rsp0_valid_o(o_rsp_valid[1][0]), .rsp0_ready_i(rsp_ready[0]),
        .rsp0_result_o(o_rsp_result[1][0]),
        .rsp1_valid_o(o_rsp_valid[1][1]), .rsp1_ready_i(rsp_ready[1]),
        .rsp1_result_o(o_rsp_result[1][1]),
        .busy_o(o_busy[1]), .grant_cnt0_o(fx_cnt0), .grant_cnt1_o(fx_cnt1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one pending result per instance plus tie-break and grant tallies.
    bit          m_busy  [2];
    bit          m_owner [2];
    bit          m_known [2];
    bit          m_prio  [2];
    logic [31:0] m_res   [2];
    int          m_cnt   [2][2];
    int          cnt_max [2] = '{65535, 7};
    bit          rr_mode [2] = '{1'b1, 1'b0};
    int          last_grant [2];

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, output bit known);
        int sh;
        sh    = int'(b % 32);
        known = 1'b1;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return $signed(a) >>> sh;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default: begin
                known = 1'b0;
                return 32'd0;
            end
        endcase
    endfunction

    function automatic int pick(input int k);
        if (req_valid[0] && req_valid[1]) return rr_mode[k] ? int'(m_prio[k]) : 0;
        if (req_valid[0]) return 0;
        if (req_valid[1]) return 1;
        return -1;
    endfunction

    function automatic bit has_space(input int k);
        return !m_busy[k] || rsp_ready[m_owner[k]];
    endfunction

    task automatic reset_model(input int k);
        m_busy[k]  = 1'b0;
        m_owner[k] = 1'b0;
        m_known[k] = 1'b1;
        m_prio[k]  = 1'b0;
        m_res[k]   = 32'd0;
        m_cnt[k][0] = 0;
        m_cnt[k][1] = 0;
        last_grant[k] = -1;
    endtask

    task automatic check_dut(input int k);
        int w;
        w = pick(k);
        for (int p = 0; p < 2; p++) begin
            check($sformatf("i%0d_req%0d_ready", k, p), o_req_ready[k][p],
                  rst_ni && has_space(k) && w == p);
            check($sformatf("i%0d_rsp%0d_valid", k, p), o_rsp_valid[k][p],
                  m_busy[k] && m_owner[k] == p);
            if (m_known[k])
                check($sformatf("i%0d_rsp%0d_result", k, p), o_rsp_result[k][p], m_res[k]);
            check($sformatf("i%0d_cnt%0d", k, p), o_cnt[k][p], m_cnt[k][p]);
        end
        check($sformatf("i%0d_busy", k), o_busy[k], m_busy[k]);
    endtask

    task automatic update_model(input int k);
        int w;
        bit fire;
        if (!rst_ni) begin
            reset_model(k);
            return;
        end
        w    = pick(k);
        fire = m_busy[k] && rsp_ready[m_owner[k]];
        last_grant[k] = -1;
        if (has_space(k) && w >= 0) begin
            last_grant[k] = w;
            m_busy[k]  = 1'b1;
            m_owner[k] = (w == 1);
            m_res[k]   = ref_alu(req_op[w], req_a[w], req_b[w], m_known[k]);
            if (m_cnt[k][w] < cnt_max[k]) m_cnt[k][w]++;
            if (rr_mode[k]) m_prio[k] = (w == 0);
        end else if (fire) begin
            m_busy[k] = 1'b0;
        end
    endtask

    // One cycle: check mid-cycle, advance the model on the edge, return 1 ns later.
    task automatic step();
        @(negedge clk_i);
        check_dut(0);
        check_dut(1);
        @(posedge clk_i);
        update_model(0);
        update_model(1);
        #1;
    endtask

    task automatic set_req(input int p, input bit v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[p] = v;
        req_op[p]    = op;
        req_a[p]     = a;
        req_b[p]     = b;
    endtask

    task automatic rand_req(input int p);
        logic [3:0] op;
        op = 4'($urandom_range(0, 10));
        if (op == 4'd10) op = OP_BAD;
        set_req(p, 1'b1, op, $urandom, $urandom);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        reset_model(0);
        reset_model(1);
        step();
        step();
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        for (int p = 0; p < 2; p++) begin
            set_req(p, 1'b0, OP_ADD, 32'd0, 32'd0);
            rsp_ready[p] = 1'b1;
        end
        do_reset();

        // Add on port 0
        set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7);
        step();
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        check("add_grant", last_grant[0], 0);
        check("add_rsp0_valid", o_rsp_valid[0][0], 1'b1);
        check("add_result", o_rsp_result[0][0], 32'd12);
        check("add_rsp1_valid", o_rsp_valid[0][1], 1'b0);
        check("add_cnt0", o_cnt[0][0], 32'd1);

        // Subtract on port 1
        set_req(1, 1'b1, OP_SUB, 32'd3, 32'd5);
        step();
        set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
        check("sub_result", o_rsp_result[0][1], 32'hFFFF_FFFE);
        check("sub_rsp1_valid", o_rsp_valid[0][1], 1'b1);
        check("sub_rsp0_valid", o_rsp_valid[0][0], 1'b0);
        step();

        // Round-robin alternation, fixed priority and counter saturation
        do_reset();
        rand_req(0);
        rand_req(1);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i < 8) check("rr_grant", last_grant[0], i % 2);
            check("fx_grant", last_grant[1], 0);
            if (last_grant[0] >= 0) rand_req(last_grant[0]);
            if (i == 7) begin
                check("rr_cnt0", o_cnt[0][0], 32'd4);
                check("rr_cnt1", o_cnt[0][1], 32'd4);
                check("fx_cnt0_sat", o_cnt[1][0], 32'd7);
            end
        end
        check("fx_cnt1_starved", o_cnt[1][1], 32'd0);
        check("fx_cnt0_hold", o_cnt[1][0], 32'd7);

        // Backpressure
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
        step();
        set_req(0, 1'b1, OP_SLL, 32'd1, 32'd4);
        rsp_ready[0] = 1'b0;
        step();
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        set_req(1, 1'b1, OP_ADD, 32'd9, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold", o_rsp_result[0][0], 32'd16);
            check("bp_req1_ready", o_req_ready[0][1], 1'b0);
        end
        rsp_ready[0] = 1'b1;
        #1;
        check("bp_req1_ready_rise", o_req_ready[0][1], 1'b1);
        step();
        check("bp_grant1", last_grant[0], 1);
        set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
        check("bp_rsp1_result", o_rsp_result[0][1], 32'd10);
        step();

        // Mid-operation asynchronous reset
        set_req(0, 1'b1, OP_ADD, 32'd2, 32'd2);
        rsp_ready[0] = 1'b0;
        step();
        set_req(1, 1'b1, OP_XOR, 32'hF0, 32'h0F);
        check("mr_busy_before", o_busy[0], 1'b1);
        #2;
        rst_ni = 1'b0;
        reset_model(0);
        reset_model(1);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("mr_busy", o_busy[k], 1'b0);
            for (int p = 0; p < 2; p++) begin
                check("mr_rsp_valid", o_rsp_valid[k][p], 1'b0);
                check("mr_rsp_result", o_rsp_result[k][p], 32'd0);
                check("mr_req_ready", o_req_ready[k][p], 1'b0);
                check("mr_cnt", o_cnt[k][p], 32'd0);
            end
        end
        step();
        rst_ni = 1'b1;
        rsp_ready[0] = 1'b1;
        step();
        check("mr_first_grant", last_grant[0], 0);
        step();
        check("mr_second_grant", last_grant[0], 1);

        // Randomized traffic; requests held until the round-robin instance accepts
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_valid[p] && $urandom_range(0, 99) < 60) rand_req(p);
                rsp_ready[p] = ($urandom_range(0, 99) < 70);
            end
            step();
            if (last_grant[0] >= 0) begin
                if ($urandom_range(0, 1) == 1) rand_req(last_grant[0]);
                else set_req(last_grant[0], 1'b0, OP_ADD, 32'd0, 32'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
